// File: rtl/write_ptr_flags_if.sv
// Producer-side bus of the write-domain pointer block: request, synchronised
// read pointer, threshold/clear controls and the resulting pointer/status flags.
interface write_ptr_flags_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              write_inc;
  logic [ADDR_W:0]   read_pointer_grey;
  logic [ADDR_W:0]   write_afull_thresh;
  logic              write_overflow_clr;
  logic              write_en;
  logic [ADDR_W-1:0] write_address;
  logic [ADDR_W:0]   write_pointer;
  logic              write_full;
  logic              write_almost_full;
  logic [ADDR_W:0]   write_level;
  logic              write_overflow;

  modport master (
    output write_inc, read_pointer_grey, write_afull_thresh, write_overflow_clr,
    input  write_en, write_address, write_pointer, write_full,
           write_almost_full, write_level, write_overflow
  );

  modport slave (
    input  write_inc, read_pointer_grey, write_afull_thresh, write_overflow_clr,
    output write_en, write_address, write_pointer, write_full,
           write_almost_full, write_level, write_overflow
  );
endinterface

// File: rtl/write_ptr_flags.sv
// Async-FIFO write-domain pointer block: binary/Gray write pointer, memory
// write strobe/address, and registered full, almost-full, level and overflow.
module write_ptr_flags #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    write_clk,
  input  logic                    write_reset_n,
  write_ptr_flags_if.slave        bus
);
  localparam int unsigned PW = ADDR_W + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          wen;

  // Next-state: pointer advance, Gray-to-binary of the read pointer, flags
  always_comb begin
    wen     = bus.write_inc & ~full_q;
    wbin_d  = wbin_q + PW'(wen);
    gray_d  = wbin_d ^ (wbin_d >> 1);
    rbin    = bus.read_pointer_grey;
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ bus.read_pointer_grey[i];
    end
    // Full when the write pointer is exactly one lap ahead of the read pointer
    full_d  = (gray_d == {~bus.read_pointer_grey[ADDR_W:ADDR_W-1],
                          bus.read_pointer_grey[ADDR_W-2:0]});
    level_d = wbin_d - rbin;
    afull_d = (level_d >= bus.write_afull_thresh);
    ovf_d   = (bus.write_inc & full_q) | (ovf_q & ~bus.write_overflow_clr);
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.write_en          = wen;
  assign bus.write_address     = wbin_q[ADDR_W-1:0];
  assign bus.write_pointer     = gray_q;
  assign bus.write_full        = full_q;
  assign bus.write_almost_full = afull_q;
  assign bus.write_level       = level_q;
  assign bus.write_overflow    = ovf_q;
endmodule

// File: tb/tb_write_ptr_flags.sv
// Directed bench for write_ptr_flags at ADDR_W = 4 (DEPTH = 16).
module tb_write_ptr_flags;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  write_ptr_flags_if #(.ADDR_W(4)) bus ();

  write_ptr_flags #(.ADDR_W(4)) dut (
    .write_clk     (clk),
    .write_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.write_inc = 1'b1;
    bus.read_pointer_grey = 5'd0;
    bus.write_afull_thresh = 5'd17;
    bus.write_overflow_clr = 1'b0;
    #12;
    checks++;
    if ({bus.write_pointer, bus.write_address, bus.write_full, bus.write_almost_full,
         bus.write_level, bus.write_overflow} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ptr=%b addr=%0d full=%b af=%b lvl=%0d ovf=%b expected all 0",
               bus.write_pointer, bus.write_address, bus.write_full, bus.write_almost_full,
               bus.write_level, bus.write_overflow);
    end
    checks++;
    if (bus.write_en !== 1'b1) begin
      errors++; $display("FAIL reset_wen: got %b expected 1", bus.write_en);
    end
    bus.write_inc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.write_level !== 5'd0 || bus.write_almost_full !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got lvl=%0d af=%b expected 0 0",
                         bus.write_level, bus.write_almost_full);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      bus.write_inc = 1'b1;
      #1;
      checks++;
      if (bus.write_address !== 4'(i) || bus.write_en !== 1'b1) begin
        errors++; $display("FAIL fill_addr[%0d]: got addr=%0d wen=%b expected %0d 1",
                           i, bus.write_address, bus.write_en, i);
      end
      tick();
      checks++;
      if (bus.write_full !== (i == 15) || bus.write_level !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_flags[%0d]: got full=%b lvl=%0d expected %b %0d",
                           i, bus.write_full, bus.write_level, (i == 15), i + 1);
      end
    end
    bus.write_inc = 1'b0;
    checks++;
    if (bus.write_pointer !== 5'b11000) begin
      errors++; $display("FAIL fill_ptr: got %b expected 11000", bus.write_pointer);
    end
    checks++;
    if (bus.write_almost_full !== 1'b0) begin
      errors++; $display("FAIL fill_thresh_over_depth: got af=%b expected 0", bus.write_almost_full);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 3; i++) begin
      bus.write_inc = 1'b1;
      #1;
      checks++;
      if (bus.write_en !== 1'b0) begin
        errors++; $display("FAIL ovf_wen[%0d]: got %b expected 0", i, bus.write_en);
      end
      tick();
      checks++;
      if (bus.write_pointer !== 5'b11000 || bus.write_address !== 4'd0 ||
          bus.write_overflow !== 1'b1 || bus.write_full !== 1'b1) begin
        errors++; $display("FAIL ovf_hold[%0d]: got ptr=%b addr=%0d ovf=%b full=%b expected 11000 0 1 1",
                           i, bus.write_pointer, bus.write_address, bus.write_overflow, bus.write_full);
      end
    end
    bus.write_overflow_clr = 1'b1;
    tick();
    checks++;
    if (bus.write_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.write_overflow);
    end
    bus.write_inc = 1'b0;
    tick();
    checks++;
    if (bus.write_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b expected 0", bus.write_overflow);
    end
    bus.write_overflow_clr = 1'b0;
  endtask

  task automatic test_full_release;
    bus.read_pointer_grey = 5'b00001;
    tick();
    checks++;
    if (bus.write_full !== 1'b0 || bus.write_level !== 5'd15) begin
      errors++; $display("FAIL release_flags: got full=%b lvl=%0d expected 0 15",
                         bus.write_full, bus.write_level);
    end
    bus.write_inc = 1'b1;
    #1;
    checks++;
    if (bus.write_en !== 1'b1 || bus.write_address !== 4'd0) begin
      errors++; $display("FAIL release_wen: got wen=%b addr=%0d expected 1 0",
                         bus.write_en, bus.write_address);
    end
    tick();
    bus.write_inc = 1'b0;
    checks++;
    if (bus.write_full !== 1'b1 || bus.write_level !== 5'd16 || bus.write_pointer !== 5'b11001) begin
      errors++; $display("FAIL refull: got full=%b lvl=%0d ptr=%b expected 1 16 11001",
                         bus.write_full, bus.write_level, bus.write_pointer);
    end
  endtask

  task automatic test_almost_full;
    bus.read_pointer_grey = 5'd0;
    bus.write_afull_thresh = 5'd12;
    pulse_reset();
    for (int i = 1; i <= 12; i++) begin
      bus.write_inc = 1'b1;
      tick();
      checks++;
      if (bus.write_almost_full !== (i >= 12) || bus.write_level !== 5'(i)) begin
        errors++; $display("FAIL afull_rise[%0d]: got af=%b lvl=%0d expected %b %0d",
                           i, bus.write_almost_full, bus.write_level, (i >= 12), i);
      end
    end
    bus.write_inc = 1'b0;
    bus.read_pointer_grey = 5'b00001;
    tick();
    checks++;
    if (bus.write_almost_full !== 1'b0 || bus.write_level !== 5'd11) begin
      errors++; $display("FAIL afull_fall: got af=%b lvl=%0d expected 0 11",
                         bus.write_almost_full, bus.write_level);
    end
    bus.write_afull_thresh = 5'd0;
    tick();
    checks++;
    if (bus.write_almost_full !== 1'b1) begin
      errors++; $display("FAIL afull_thresh0: got %b expected 1", bus.write_almost_full);
    end
    bus.write_afull_thresh = 5'd17;
    tick();
    checks++;
    if (bus.write_almost_full !== 1'b0) begin
      errors++; $display("FAIL afull_thresh17: got %b expected 0", bus.write_almost_full);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] nxt;
    logic [4:0] rd;
    bus.read_pointer_grey = 5'd0;
    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      nxt = 5'(i + 1);
      rd  = (i == 0) ? 5'd0 : 5'(i - 1);
      bus.read_pointer_grey = gray5(rd);
      bus.write_inc = 1'b1;
      #1;
      checks++;
      if (bus.write_address !== 4'(i % 16)) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, bus.write_address, i % 16);
      end
      tick();
      checks++;
      if (bus.write_pointer !== gray5(nxt) || bus.write_full !== 1'b0 ||
          bus.write_level !== ((i == 0) ? 5'd1 : 5'd2)) begin
        errors++; $display("FAIL wrap_step[%0d]: got ptr=%b full=%b lvl=%0d expected %b 0 %0d",
                           i, bus.write_pointer, bus.write_full, bus.write_level, gray5(nxt),
                           (i == 0) ? 1 : 2);
      end
    end
    bus.write_inc = 1'b0;
  endtask

  task automatic test_async_reset;
    bus.read_pointer_grey = 5'd0;
    bus.write_afull_thresh = 5'd4;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      bus.write_inc = 1'b1;
      tick();
    end
    bus.write_inc = 1'b0;
    checks++;
    if (bus.write_level !== 5'd9 || bus.write_almost_full !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got lvl=%0d af=%b expected 9 1",
                         bus.write_level, bus.write_almost_full);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.write_pointer, bus.write_address, bus.write_full, bus.write_almost_full,
         bus.write_level, bus.write_overflow} !== 16'd0) begin
      errors++; $display("FAIL areset_clear: got ptr=%b addr=%0d lvl=%0d af=%b expected all 0",
                         bus.write_pointer, bus.write_address, bus.write_level, bus.write_almost_full);
    end
    #1;
    rst_n = 1'b1;
    bus.write_inc = 1'b1;
    #1;
    checks++;
    if (bus.write_address !== 4'd0) begin
      errors++; $display("FAIL areset_addr: got %0d expected 0", bus.write_address);
    end
    tick();
    bus.write_inc = 1'b0;
    checks++;
    if (bus.write_address !== 4'd1 || bus.write_pointer !== 5'b00001 || bus.write_level !== 5'd1) begin
      errors++; $display("FAIL areset_first_write: got addr=%0d ptr=%b lvl=%0d expected 1 00001 1",
                         bus.write_address, bus.write_pointer, bus.write_level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_release();
    test_almost_full();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
